// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: entry tag width, null tag, entry state and payload.
// Imported by the interface, the ROB core and the bench.
package rob_pkg;

  localparam int ROB_SIZE_DEF = 16;
  localparam int ROB_ENTRY_W  = 5;

  typedef logic [ROB_ENTRY_W-1:0] rob_entry_t;

  localparam rob_entry_t ENTRY_NULL = 5'd16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ISSUED = 2'd1,
    ST_READY  = 2'd2
  } ent_state_t;

  typedef struct packed {
    logic [5:0]  rd;
    logic [31:0] pc;
    logic [31:0] pred_pc;
    logic [31:0] act_pc;
    logic [31:0] result;
    logic        is_branch;
    logic        is_store;
  } rob_ent_t;

endpackage

// File: rtl/rob_if.sv
// Issue, CDB broadcast, operand query, commit and rollback signals of the ROB.
// master = surrounding core, slave = ROB.
interface rob_if;
  import rob_pkg::*;

  logic        issue_valid;
  logic [5:0]  issue_rd;
  logic [31:0] issue_pc;
  logic [31:0] issue_pred_pc;
  logic        issue_is_branch;
  logic        issue_is_store;
  logic        rob_full;
  rob_entry_t  rob_tail_entry;

  rob_entry_t  query_j;
  rob_entry_t  query_k;
  logic        query_j_ready;
  logic        query_k_ready;
  logic [31:0] query_j_value;
  logic [31:0] query_k_value;

  logic        alu_broadcast;
  rob_entry_t  alu_entry;
  logic [31:0] alu_result;
  logic [31:0] alu_pc_out;
  logic [31:0] alu_pc_init;
  logic        lsb_broadcast;
  rob_entry_t  lsb_entry;
  logic [31:0] lsb_result;

  logic        rob_commit;
  rob_entry_t  rob_entry;
  logic [31:0] rob_result;
  logic [5:0]  commit_rd;
  logic        commit_is_store;
  logic        rollback;
  logic [31:0] rollback_pc;

  modport master (
    output issue_valid, issue_rd, issue_pc, issue_pred_pc, issue_is_branch, issue_is_store,
    input  rob_full, rob_tail_entry,
    output query_j, query_k,
    input  query_j_ready, query_k_ready, query_j_value, query_k_value,
    output alu_broadcast, alu_entry, alu_result, alu_pc_out, alu_pc_init,
    output lsb_broadcast, lsb_entry, lsb_result,
    input  rob_commit, rob_entry, rob_result, commit_rd, commit_is_store,
    input  rollback, rollback_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_pc, issue_pred_pc, issue_is_branch, issue_is_store,
    output rob_full, rob_tail_entry,
    input  query_j, query_k,
    output query_j_ready, query_k_ready, query_j_value, query_k_value,
    input  alu_broadcast, alu_entry, alu_result, alu_pc_out, alu_pc_init,
    input  lsb_broadcast, lsb_entry, lsb_result,
    output rob_commit, rob_entry, rob_result, commit_rd, commit_is_store,
    output rollback, rollback_pc
  );

endinterface

// File: rtl/rob.sv
// Circular reorder buffer: in-order commit of CDB-completed entries, flush on branch mispredict.
// Commit one edge after head turns READY; issue refused when full; rdy low freezes all state.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  rob_if.slave bus
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  typedef logic [IDX_W-1:0] idx_t;

  ent_state_t     st  [ROB_SIZE];
  rob_ent_t       ent [ROB_SIZE];
  idx_t           head;
  idx_t           tail;
  logic [IDX_W:0] count;

  logic accept;
  logic issue_fire;
  logic commit_fire;
  logic mispredict;
  logic alu_hit;
  logic lsb_hit;
  idx_t alu_idx;
  idx_t lsb_idx;
  logic unused_pc_init;

  function automatic idx_t wrap_inc(input idx_t p);
    return (int'(p) == ROB_SIZE - 1) ? '0 : p + idx_t'(1);
  endfunction

  function automatic logic tag_ok(input rob_entry_t t);
    return int'(t) < ROB_SIZE;
  endfunction

  // Broadcast bypass wins over stored state so a consumer sees a value in its completion cycle.
  function automatic logic [32:0] lookup(input rob_entry_t tag);
    logic [32:0] r;
    r = '0;
    if (tag_ok(tag)) begin
      if (alu_hit && bus.alu_entry == tag)
        r = {1'b1, bus.alu_result};
      else if (lsb_hit && bus.lsb_entry == tag)
        r = {1'b1, bus.lsb_result};
      else
        r = {st[tag[IDX_W-1:0]] == ST_READY, ent[tag[IDX_W-1:0]].result};
    end
    return r;
  endfunction

  assign unused_pc_init = ^bus.alu_pc_init;

  // The cycle after a flush drops new work: the front end is still redirecting.
  assign accept      = rdy && !bus.rollback;
  assign alu_idx     = bus.alu_entry[IDX_W-1:0];
  assign lsb_idx     = bus.lsb_entry[IDX_W-1:0];
  assign alu_hit     = accept && bus.alu_broadcast && tag_ok(bus.alu_entry);
  assign lsb_hit     = accept && bus.lsb_broadcast && tag_ok(bus.lsb_entry);

  assign bus.rob_full       = (int'(count) == ROB_SIZE);
  assign bus.rob_tail_entry = ROB_ENTRY_W'(tail);

  assign issue_fire  = accept && bus.issue_valid && !bus.rob_full;
  assign commit_fire = rdy && (st[head] == ST_READY);
  assign mispredict  = commit_fire && ent[head].is_branch &&
                       (ent[head].act_pc != ent[head].pred_pc);

  always_comb begin
    bus.query_j_ready = FALSE;
    bus.query_j_value = '0;
    bus.query_k_ready = FALSE;
    bus.query_k_value = '0;
    {bus.query_j_ready, bus.query_j_value} = lookup(bus.query_j);
    {bus.query_k_ready, bus.query_k_value} = lookup(bus.query_k);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        st[i]  <= ST_EMPTY;
        ent[i] <= '0;
      end
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      bus.rob_commit      <= FALSE;
      bus.rob_entry       <= ENTRY_NULL;
      bus.rob_result      <= '0;
      bus.commit_rd       <= '0;
      bus.commit_is_store <= FALSE;
      bus.rollback        <= FALSE;
      bus.rollback_pc     <= '0;
    end else if (rdy) begin
      bus.rob_commit <= FALSE;
      bus.rollback   <= FALSE;

      if (alu_hit && st[alu_idx] == ST_ISSUED) begin
        st[alu_idx]         <= ST_READY;
        ent[alu_idx].result <= bus.alu_result;
        ent[alu_idx].act_pc <= bus.alu_pc_out;
      end
      if (lsb_hit && st[lsb_idx] == ST_ISSUED) begin
        st[lsb_idx]         <= ST_READY;
        ent[lsb_idx].result <= bus.lsb_result;
      end

      // act_pc starts at the prediction so non-ALU entries never look mispredicted.
      if (issue_fire) begin
        st[tail]  <= ST_ISSUED;
        ent[tail] <= '{rd:        bus.issue_rd,
                       pc:        bus.issue_pc,
                       pred_pc:   bus.issue_pred_pc,
                       act_pc:    bus.issue_pred_pc,
                       result:    32'd0,
                       is_branch: bus.issue_is_branch,
                       is_store:  bus.issue_is_store};
        tail      <= wrap_inc(tail);
      end

      if (commit_fire) begin
        bus.rob_commit      <= TRUE;
        bus.rob_entry       <= ROB_ENTRY_W'(head);
        bus.rob_result      <= ent[head].result;
        bus.commit_rd       <= ent[head].rd;
        bus.commit_is_store <= ent[head].is_store;
        st[head]            <= ST_EMPTY;
        head                <= wrap_inc(head);
      end

      count <= count + {{IDX_W{1'b0}}, issue_fire} - {{IDX_W{1'b0}}, commit_fire};

      if (mispredict) begin
        bus.rollback    <= TRUE;
        bus.rollback_pc <= ent[head].act_pc;
        for (int i = 0; i < ROB_SIZE; i++)
          st[i] <= ST_EMPTY;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end
    end else begin
      bus.rob_commit <= FALSE;
      bus.rollback   <= FALSE;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: fill/wrap, ordered commit, dual CDB + bypass, pause, mispredict, async reset.
module tb_rob;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_chk  = 0;
  int   n_pass = 0;

  rob_if bus ();

  rob #(.ROB_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    bus.issue_valid     = 1'b0;
    bus.issue_rd        = '0;
    bus.issue_pc        = '0;
    bus.issue_pred_pc   = '0;
    bus.issue_is_branch = 1'b0;
    bus.issue_is_store  = 1'b0;
    bus.query_j         = ENTRY_NULL;
    bus.query_k         = ENTRY_NULL;
    bus.alu_broadcast   = 1'b0;
    bus.alu_entry       = '0;
    bus.alu_result      = '0;
    bus.alu_pc_out      = '0;
    bus.alu_pc_init     = '0;
    bus.lsb_broadcast   = 1'b0;
    bus.lsb_entry       = '0;
    bus.lsb_result      = '0;
  endtask

  task automatic do_issue(input logic [5:0] rd, input logic [31:0] pc, input logic [31:0] pred,
                          input logic br, input logic stq);
    bus.issue_valid     = 1'b1;
    bus.issue_rd        = rd;
    bus.issue_pc        = pc;
    bus.issue_pred_pc   = pred;
    bus.issue_is_branch = br;
    bus.issue_is_store  = stq;
    tick();
    bus.issue_valid     = 1'b0;
  endtask

  task automatic alu(input rob_entry_t e, input logic [31:0] res, input logic [31:0] npc);
    bus.alu_broadcast = 1'b1;
    bus.alu_entry     = e;
    bus.alu_result    = res;
    bus.alu_pc_out    = npc;
  endtask

  task automatic chk_commit(input string tag, input rob_entry_t e, input logic [31:0] res,
                            input logic [5:0] rd);
    check({tag, ".commit"}, bus.rob_commit, 1);
    check({tag, ".entry"}, bus.rob_entry, e);
    check({tag, ".result"}, bus.rob_result, res);
    check({tag, ".rd"}, bus.commit_rd, rd);
  endtask

  initial begin
    clear_in();
    rdy = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    check("rst.commit", bus.rob_commit, 0);
    check("rst.rollback", bus.rollback, 0);
    check("rst.entry", bus.rob_entry, ENTRY_NULL);
    check("rst.full", bus.rob_full, 0);
    check("rst.tail", bus.rob_tail_entry, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to capacity, try a 17th, then free one slot
    for (int i = 0; i < 16; i++)
      do_issue(6'(i + 1), 32'(i * 4), 32'(i * 4 + 4), 1'b0, 1'b0);
    check("fill.full", bus.rob_full, 1);
    check("fill.tail_wrap", bus.rob_tail_entry, 0);
    do_issue(6'd63, 32'h999, 32'h99c, 1'b0, 1'b0);
    check("fill.17th_full", bus.rob_full, 1);
    check("fill.17th_tail", bus.rob_tail_entry, 0);
    alu(5'd0, 32'hA0, 32'h4);
    tick();
    clear_in();
    check("fill.no_early_commit", bus.rob_commit, 0);
    tick();
    chk_commit("fill.c0", 5'd0, 32'hA0, 6'd1);
    check("fill.not_full", bus.rob_full, 0);
    rst = 1'b1;
    #1;
    check("fill.rst_commit", bus.rob_commit, 0);
    check("fill.rst_full", bus.rob_full, 0);
    #1 rst = 1'b0;

    // Out-of-order completion, in-order commit
    do_issue(6'd2, 32'h10, 32'h14, 1'b0, 1'b0);
    do_issue(6'd3, 32'h14, 32'h18, 1'b0, 1'b0);
    alu(5'd1, 32'h55, 32'h18);
    tick();
    clear_in();
    check("ord.e1_only", bus.rob_commit, 0);
    alu(5'd0, 32'h33, 32'h14);
    tick();
    clear_in();
    check("ord.ready_edge", bus.rob_commit, 0);
    tick();
    chk_commit("ord.c0", 5'd0, 32'h33, 6'd2);
    tick();
    chk_commit("ord.c1", 5'd1, 32'h55, 6'd3);
    tick();
    check("ord.idle", bus.rob_commit, 0);

    // Dual broadcast and query bypass
    do_issue(6'd4, 32'h20, 32'h24, 1'b0, 1'b0);
    do_issue(6'd7, 32'h24, 32'h28, 1'b0, 1'b1);
    bus.query_j = 5'd3;
    bus.query_k = 5'd2;
    #1;
    check("byp.j_pending", bus.query_j_ready, 0);
    alu(5'd2, 32'd7, 32'h24);
    bus.lsb_broadcast = 1'b1;
    bus.lsb_entry     = 5'd3;
    bus.lsb_result    = 32'd9;
    #1;
    check("byp.j_ready", bus.query_j_ready, 1);
    check("byp.j_value", bus.query_j_value, 9);
    check("byp.k_ready", bus.query_k_ready, 1);
    check("byp.k_value", bus.query_k_value, 7);
    tick();
    clear_in();
    bus.query_j = 5'd3;
    #1;
    check("byp.j_stored", bus.query_j_value, 9);
    check("byp.null_ready", bus.query_k_ready, 0);
    check("byp.null_value", bus.query_k_value, 0);
    tick();
    chk_commit("byp.c2", 5'd2, 32'd7, 6'd4);
    check("byp.c2_load", bus.commit_is_store, 0);
    tick();
    chk_commit("byp.c3", 5'd3, 32'd9, 6'd7);
    check("byp.c3_store", bus.commit_is_store, 1);
    clear_in();

    // Pause with a READY head; correctly predicted branch
    do_issue(6'd5, 32'h40, 32'h50, 1'b1, 1'b0);
    alu(5'd4, 32'h77, 32'h50);
    tick();
    clear_in();
    rdy = 1'b0;
    bus.issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause.no_commit", bus.rob_commit, 0);
      check("pause.tail_held", bus.rob_tail_entry, 5);
    end
    bus.issue_valid = 1'b0;
    rdy = 1'b1;
    tick();
    chk_commit("pause.c4", 5'd4, 32'h77, 6'd5);
    check("pause.no_rollback", bus.rollback, 0);

    // Mispredicted branch
    do_issue(6'd9, 32'h100, 32'h104, 1'b1, 1'b0);
    do_issue(6'd10, 32'h104, 32'h108, 1'b0, 1'b0);
    alu(5'd5, 32'h1, 32'h200);
    tick();
    clear_in();
    tick();
    chk_commit("mis.c5", 5'd5, 32'h1, 6'd9);
    check("mis.rollback", bus.rollback, 1);
    check("mis.rollback_pc", bus.rollback_pc, 32'h200);
    check("mis.tail_reset", bus.rob_tail_entry, 0);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 6'd11;
    tick();
    bus.issue_valid = 1'b0;
    check("mis.rollback_1cyc", bus.rollback, 0);
    check("mis.issue_dropped", bus.rob_tail_entry, 0);
    do_issue(6'd12, 32'h200, 32'h204, 1'b0, 1'b0);
    check("mis.first_issue", bus.rob_tail_entry, 1);

    // Async reset with live entries and a commit on the outputs
    for (int i = 0; i < 5; i++)
      do_issue(6'(20 + i), 32'h300, 32'h304, 1'b0, 1'b0);
    alu(5'd0, 32'h5A, 32'h204);
    tick();
    clear_in();
    tick();
    chk_commit("ar.c0", 5'd0, 32'h5A, 6'd12);
    rst = 1'b1;
    #1;
    check("ar.commit", bus.rob_commit, 0);
    check("ar.entry", bus.rob_entry, ENTRY_NULL);
    check("ar.result", bus.rob_result, 0);
    check("ar.rd", bus.commit_rd, 0);
    check("ar.full", bus.rob_full, 0);
    check("ar.tail", bus.rob_tail_entry, 0);
    #1 rst = 1'b0;
    do_issue(6'd33, 32'h400, 32'h404, 1'b0, 1'b0);
    check("ar.first_issue", bus.rob_tail_entry, 1);
    alu(5'd0, 32'hBEEF, 32'h404);
    tick();
    clear_in();
    tick();
    chk_commit("ar.fresh", 5'd0, 32'hBEEF, 6'd33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
